readout_stream_arbiter: RTL and testbench

- Merges two indexed readout streams onto one output packet stream with backpressure, e.g. FMPS readout (source A) and a second indexed readout stream (source B), toward one outgoing packet link.
- Sources cannot stall, so each source is buffered in its own FIFO.
- Packets are admitted whole or dropped whole, then forwarded in round-robin order, one complete packet per grant.
- A source tag is added to every output word.

---
 rtl/readout_stream_arbiter_if.sv | 48 ++++
 rtl/readout_stream_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_readout_stream_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/readout_stream_arbiter_if.sv
// Bus bundle for readout_stream_arbiter: two unstallable indexed input streams,
// one backpressured output packet stream, and per-source status.
interface readout_stream_arbiter_if #(
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_AW     = 6
);
    logic [INDEX_WIDTH-1:0] aIndex;
    logic [DATA_WIDTH-1:0]  aData;
    logic                   aValid;
    logic                   aLast;
    logic [INDEX_WIDTH-1:0] bIndex;
    logic [DATA_WIDTH-1:0]  bData;
    logic                   bValid;
    logic                   bLast;

    logic [INDEX_WIDTH-1:0] outIndex;
    logic [DATA_WIDTH-1:0]  outData;
    logic                   outSource;
    logic                   outLast;
    logic                   outValid;
    logic                   outReady;

    logic                   clearStrobe;
    logic                   aOverflow;
    logic                   bOverflow;
    logic [15:0]            aDropCount;
    logic [15:0]            bDropCount;
    logic [FIFO_AW:0]       aLevel;
    logic [FIFO_AW:0]       bLevel;
    logic                   grantB;

    modport slave (
        input  aIndex, aData, aValid, aLast,
        input  bIndex, bData, bValid, bLast,
        input  outReady, clearStrobe,
        output outIndex, outData, outSource, outLast, outValid,
        output aOverflow, bOverflow, aDropCount, bDropCount, aLevel, bLevel, grantB
    );

    modport master (
        output aIndex, aData, aValid, aLast,
        output bIndex, bData, bValid, bLast,
        output outReady, clearStrobe,
        input  outIndex, outData, outSource, outLast, outValid,
        input  aOverflow, bOverflow, aDropCount, bDropCount, aLevel, bLevel, grantB
    );
endinterface

// File: rtl/readout_stream_arbiter.sv
// Buffers two readout streams in per-source FIFOs (whole-packet admit/drop) and
// forwards complete packets round-robin onto one tagged output stream.
module readout_stream_arbiter #(
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_AW     = 6
) (
    input  logic                     sysClk,
    input  logic                     sysReset_n,
    readout_stream_arbiter_if.slave  bus
);
    localparam int unsigned WW     = 1 + INDEX_WIDTH + DATA_WIDTH;
    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned MAXLEN = 2 ** INDEX_WIDTH;
    localparam int unsigned LW     = FIFO_AW + 1;

    if (FIFO_AW < INDEX_WIDTH + 1) begin : g_bad_cfg
        $error("readout_stream_arbiter: FIFO_AW must be >= INDEX_WIDTH+1");
    end

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_e;

    logic                   in_vld [2];
    logic                   in_lst [2];
    logic [INDEX_WIDTH-1:0] in_idx [2];
    logic [DATA_WIDTH-1:0]  in_dat [2];
    logic [WW-1:0]          head_w [2];
    logic [WW-1:0]          next_w [2];
    logic                   elig   [2];
    logic                   pop    [2];
    logic                   ovf    [2];
    logic [15:0]            drops  [2];
    logic [LW-1:0]          level  [2];

    assign in_vld[0] = bus.aValid;  assign in_vld[1] = bus.bValid;
    assign in_lst[0] = bus.aLast;   assign in_lst[1] = bus.bLast;
    assign in_idx[0] = bus.aIndex;  assign in_idx[1] = bus.bIndex;
    assign in_dat[0] = bus.aData;   assign in_dat[1] = bus.bData;

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic [WW-1:0]      mem_q [DEPTH];
        logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [LW-1:0]      level_q, level_d, pkt_cnt_q, pkt_cnt_d;
        logic               in_pkt_q, in_pkt_d, dropping_q, dropping_d;
        logic               ovf_q, ovf_d, wr_en, drop_now, inc, dec;
        logic [15:0]        drop_cnt_q, drop_cnt_d;

        // Admission: decided once at packet start, then followed through to last.
        always_comb begin
            wr_en      = 1'b0;
            drop_now   = 1'b0;
            in_pkt_d   = in_pkt_q;
            dropping_d = dropping_q;
            if (in_vld[g]) begin
                in_pkt_d = !in_lst[g];
                if (!in_pkt_q) begin
                    if (level_q <= LW'(DEPTH - MAXLEN)) begin
                        wr_en      = 1'b1;
                        dropping_d = 1'b0;
                    end else begin
                        drop_now   = 1'b1;
                        dropping_d = !in_lst[g];
                    end
                end else begin
                    wr_en = !dropping_q && (level_q != LW'(DEPTH));
                    if (in_lst[g]) dropping_d = 1'b0;
                end
            end
            inc       = wr_en && in_lst[g];
            dec       = pop[g] && head_w[g][WW-1];
            wr_ptr_d  = wr_ptr_q + FIFO_AW'(wr_en);
            rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop[g]);
            level_d   = level_q + LW'(wr_en) - LW'(pop[g]);
            pkt_cnt_d = pkt_cnt_q + LW'(inc) - LW'(dec);
            // A drop coinciding with a clear survives the clear.
            if (bus.clearStrobe) begin
                ovf_d      = drop_now;
                drop_cnt_d = 16'(drop_now);
            end else begin
                ovf_d      = ovf_q || drop_now;
                drop_cnt_d = drop_cnt_q + 16'(drop_now && (drop_cnt_q != 16'hFFFF));
            end
        end

        always_ff @(posedge sysClk) begin
            if (wr_en) mem_q[wr_ptr_q] <= {in_lst[g], in_idx[g], in_dat[g]};
        end

        always_ff @(posedge sysClk or negedge sysReset_n) begin
            if (!sysReset_n) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                pkt_cnt_q  <= '0;
                in_pkt_q   <= 1'b0;
                dropping_q <= 1'b0;
                ovf_q      <= 1'b0;
                drop_cnt_q <= '0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                level_q    <= level_d;
                pkt_cnt_q  <= pkt_cnt_d;
                in_pkt_q   <= in_pkt_d;
                dropping_q <= dropping_d;
                ovf_q      <= ovf_d;
                drop_cnt_q <= drop_cnt_d;
            end
        end

        assign head_w[g] = mem_q[rd_ptr_q];
        assign next_w[g] = mem_q[rd_ptr_q + FIFO_AW'(1)];
        assign elig[g]   = (pkt_cnt_q != '0);
        assign ovf[g]    = ovf_q;
        assign drops[g]  = drop_cnt_q;
        assign level[g]  = level_q;
    end

    state_e        state_q, state_d;
    logic          grant_b_q, grant_b_d;
    logic          out_vld_q, out_vld_d;
    logic          out_src_q, out_src_d;
    logic [WW-1:0] out_word_q, out_word_d;

    // Output register mirrors the granted FIFO head; the FIFO pops on transfer.
    always_comb begin
        state_d    = state_q;
        grant_b_d  = grant_b_q;
        out_vld_d  = out_vld_q;
        out_src_d  = out_src_q;
        out_word_d = out_word_q;
        pop[0]     = 1'b0;
        pop[1]     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig[0] && (!elig[1] || grant_b_q)) begin
                    state_d    = SEND_A;
                    grant_b_d  = 1'b0;
                    out_vld_d  = 1'b1;
                    out_src_d  = 1'b0;
                    out_word_d = head_w[0];
                end else if (elig[1]) begin
                    state_d    = SEND_B;
                    grant_b_d  = 1'b1;
                    out_vld_d  = 1'b1;
                    out_src_d  = 1'b1;
                    out_word_d = head_w[1];
                end
            end
            SEND_A, SEND_B: begin
                if (out_vld_q && bus.outReady) begin
                    if (state_q == SEND_B) pop[1] = 1'b1;
                    else                   pop[0] = 1'b1;
                    if (out_word_q[WW-1]) begin
                        state_d    = IDLE;
                        out_vld_d  = 1'b0;
                        out_src_d  = 1'b0;
                        out_word_d = '0;
                    end else begin
                        out_word_d = (state_q == SEND_B) ? next_w[1] : next_w[0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q    <= IDLE;
            grant_b_q  <= 1'b1;
            out_vld_q  <= 1'b0;
            out_src_q  <= 1'b0;
            out_word_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_b_q  <= grant_b_d;
            out_vld_q  <= out_vld_d;
            out_src_q  <= out_src_d;
            out_word_q <= out_word_d;
        end
    end

    assign bus.outValid   = out_vld_q;
    assign bus.outSource  = out_src_q;
    assign bus.outLast    = out_word_q[WW-1];
    assign bus.outIndex   = out_word_q[DATA_WIDTH +: INDEX_WIDTH];
    assign bus.outData    = out_word_q[DATA_WIDTH-1:0];
    assign bus.grantB     = grant_b_q;
    assign bus.aOverflow  = ovf[0];
    assign bus.bOverflow  = ovf[1];
    assign bus.aDropCount = drops[0];
    assign bus.bDropCount = drops[1];
    assign bus.aLevel     = level[0];
    assign bus.bLevel     = level[1];
endmodule

// File: tb/tb_readout_stream_arbiter.sv
// Directed self-checking bench for readout_stream_arbiter (default parameters).
module tb_readout_stream_arbiter;
    logic sysClk = 1'b0;
    logic sysReset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 sysClk = ~sysClk;

    readout_stream_arbiter_if bus ();

    readout_stream_arbiter dut (
        .sysClk     (sysClk),
        .sysReset_n (sysReset_n),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.aValid = 1'b0; bus.aLast = 1'b0; bus.aIndex = '0; bus.aData = '0;
        bus.bValid = 1'b0; bus.bLast = 1'b0; bus.bIndex = '0; bus.bData = '0;
        bus.clearStrobe = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sysReset_n = 1'b0;
        @(negedge sysClk);
        @(negedge sysClk);
        sysReset_n = 1'b1;
        @(negedge sysClk);
    endtask

    task automatic push_pkt(input logic src, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            if (src) begin
                bus.bValid = 1'b1; bus.bIndex = 5'(i); bus.bData = base + 32'(i); bus.bLast = (i == len - 1);
            end else begin
                bus.aValid = 1'b1; bus.aIndex = 5'(i); bus.aData = base + 32'(i); bus.aLast = (i == len - 1);
            end
            @(negedge sysClk);
        end
        idle_inputs();
    endtask

    task automatic exp_word(input string tag, input logic src, input int idx,
                            input logic [31:0] d, input logic last);
        chk({tag, "_valid"}, 64'(bus.outValid), 64'd1);
        chk({tag, "_src"},   64'(bus.outSource), 64'(src));
        chk({tag, "_idx"},   64'(bus.outIndex), 64'(idx));
        chk({tag, "_data"},  64'(bus.outData), 64'(d));
        chk({tag, "_last"},  64'(bus.outLast), 64'(last));
        @(negedge sysClk);
    endtask

    initial begin
        int  k, cyc, nw, ka, kb;
        logic exp_src, rdy;
        logic [3:0] pat;

        bus.outReady = 1'b1;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(bus.outValid), 64'd0);
        chk("rst_last",  64'(bus.outLast), 64'd0);
        chk("rst_index", 64'(bus.outIndex), 64'd0);
        chk("rst_data",  64'(bus.outData), 64'd0);
        chk("rst_src",   64'(bus.outSource), 64'd0);
        chk("rst_grantB", 64'(bus.grantB), 64'd1);
        chk("rst_alevel", 64'(bus.aLevel), 64'd0);
        chk("rst_blevel", 64'(bus.bLevel), 64'd0);
        chk("rst_aovf",  64'(bus.aOverflow), 64'd0);
        chk("rst_bdrop", 64'(bus.bDropCount), 64'd0);

        // Single 4-word A packet: outValid rises one edge after the last-word edge
        push_pkt(1'b0, 4, 32'h100);
        chk("t1_latency_low", 64'(bus.outValid), 64'd0);
        @(negedge sysClk);
        chk("t1_level", 64'(bus.aLevel), 64'd4);
        for (int i = 0; i < 4; i++) exp_word("t1_w", 1'b0, i, 32'h100 + 32'(i), i == 3);
        chk("t1_done", 64'(bus.outValid), 64'd0);
        chk("t1_level_empty", 64'(bus.aLevel), 64'd0);

        // Simultaneous 3-word packets on A and B, twice: A then B each round
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                bus.aValid = 1'b1; bus.aIndex = 5'(i); bus.aData = 32'hA0 + 32'(i); bus.aLast = (i == 2);
                bus.bValid = 1'b1; bus.bIndex = 5'(i); bus.bData = 32'hB0 + 32'(i); bus.bLast = (i == 2);
                @(negedge sysClk);
            end
            idle_inputs();
            @(negedge sysClk);
            chk("t2_grant_a", 64'(bus.grantB), 64'd0);
            for (int i = 0; i < 3; i++) exp_word("t2_a", 1'b0, i, 32'hA0 + 32'(i), i == 2);
            chk("t2_gap", 64'(bus.outValid), 64'd0);
            @(negedge sysClk);
            for (int i = 0; i < 3; i++) exp_word("t2_b", 1'b1, i, 32'hB0 + 32'(i), i == 2);
            chk("t2_done", 64'(bus.outValid), 64'd0);
            chk("t2_grantB", 64'(bus.grantB), 64'd1);
        end

        // 32-word B packet with outReady pattern 1,0,0,1
        push_pkt(1'b1, 32, 32'hB000);
        @(negedge sysClk);
        pat = 4'b1001;
        k = 0;
        cyc = 0;
        while (k < 32 && cyc < 200) begin
            chk("t3_valid", 64'(bus.outValid), 64'd1);
            chk("t3_idx",   64'(bus.outIndex), 64'(k));
            chk("t3_data",  64'(bus.outData), 64'(32'hB000 + 32'(k)));
            chk("t3_last",  64'(bus.outLast), 64'(k == 31));
            chk("t3_src",   64'(bus.outSource), 64'd1);
            rdy = pat[cyc % 4];
            bus.outReady = rdy;
            @(negedge sysClk);
            if (rdy) k++;
            cyc++;
        end
        chk("t3_count", 64'(k), 64'd32);
        chk("t3_done", 64'(bus.outValid), 64'd0);

        // Overflow: two full packets fit exactly, the third is dropped
        bus.outReady = 1'b0;
        push_pkt(1'b0, 32, 32'h200);
        push_pkt(1'b0, 32, 32'h300);
        chk("t4_level_full", 64'(bus.aLevel), 64'd64);
        chk("t4_no_ovf", 64'(bus.aOverflow), 64'd0);
        push_pkt(1'b0, 32, 32'h400);
        chk("t4_ovf", 64'(bus.aOverflow), 64'd1);
        chk("t4_drop", 64'(bus.aDropCount), 64'd1);
        chk("t4_level", 64'(bus.aLevel), 64'd64);
        chk("t4_stall_data", 64'(bus.outData), 64'h200);
        chk("t4_bovf", 64'(bus.bOverflow), 64'd0);
        bus.clearStrobe = 1'b1;
        @(negedge sysClk);
        bus.clearStrobe = 1'b0;
        chk("t4_clr_ovf", 64'(bus.aOverflow), 64'd0);
        chk("t4_clr_drop", 64'(bus.aDropCount), 64'd0);
        // Clear coinciding with a new drop
        bus.clearStrobe = 1'b1;
        bus.aValid = 1'b1; bus.aLast = 1'b1; bus.aIndex = '0; bus.aData = 32'h500;
        @(negedge sysClk);
        idle_inputs();
        chk("t4_clrdrop_ovf", 64'(bus.aOverflow), 64'd1);
        chk("t4_clrdrop_cnt", 64'(bus.aDropCount), 64'd1);
        chk("t4_clrdrop_lvl", 64'(bus.aLevel), 64'd64);

        // Reset in the middle of a transfer
        bus.outReady = 1'b1;
        repeat (3) @(negedge sysClk);
        chk("t5_mid_data", 64'(bus.outData), 64'h203);
        chk("t5_mid_level", 64'(bus.aLevel), 64'd61);
        #2 sysReset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(bus.outValid), 64'd0);
        chk("t5_rst_level", 64'(bus.aLevel), 64'd0);
        chk("t5_rst_data", 64'(bus.outData), 64'd0);
        chk("t5_rst_ovf", 64'(bus.aOverflow), 64'd0);
        @(negedge sysClk);
        sysReset_n = 1'b1;
        @(negedge sysClk);
        chk("t5_no_partial", 64'(bus.outValid), 64'd0);
        push_pkt(1'b0, 2, 32'h55);
        @(negedge sysClk);
        exp_word("t5_w0", 1'b0, 0, 32'h55, 1'b0);
        exp_word("t5_w1", 1'b0, 1, 32'h56, 1'b1);
        chk("t5_done", 64'(bus.outValid), 64'd0);

        // Continuous 1-word packets on both sources
        do_reset();
        bus.outReady = 1'b1;
        ka = 0; kb = 0; nw = 0; exp_src = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bus.aValid = 1'b1; bus.aLast = 1'b1; bus.aIndex = '0; bus.aData = 32'hA000 + 32'(c);
            bus.bValid = 1'b1; bus.bLast = 1'b1; bus.bIndex = '0; bus.bData = 32'hB000 + 32'(c);
            @(negedge sysClk);
            if (bus.outValid) begin
                nw++;
                chk("t6_src", 64'(bus.outSource), 64'(exp_src));
                chk("t6_last", 64'(bus.outLast), 64'd1);
                if (!exp_src) begin
                    chk("t6_adata", 64'(bus.outData), 64'(32'hA000 + 32'(ka)));
                    ka++;
                end else begin
                    chk("t6_bdata", 64'(bus.outData), 64'(32'hB000 + 32'(kb)));
                    kb++;
                end
                exp_src = !exp_src;
            end
        end
        idle_inputs();
        chk("t6_words", 64'(nw), 64'd50);
        chk("t6_aovf", 64'(bus.aOverflow), 64'd1);
        chk("t6_bovf", 64'(bus.bOverflow), 64'd1);
        chk("t6_adrop_nz", 64'(bus.aDropCount != 16'd0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
